// File: rtl/icb_rr_arbiter_if.sv
// ICB point-to-point bundle used on both sides of the round-robin arbiter.
//   master modport : requester side (drives command, accepts response)
//   slave  modport : responder side (accepts command, drives response)
// Signals: icb_cmd_{valid,ready,addr,read,wdata,wmask},
//          icb_rsp_{valid,ready,rdata,err}
interface icb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [AW-1:0]   icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic [DW-1:0]   icb_rsp_rdata;
  logic            icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/icb_rr_arbiter.sv
// Two-master round-robin ICB arbiter in front of a single ICB slave that
// supports one outstanding transaction. A grant is held from command
// acceptance until the response handshake completes.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   m0, m1     : requester ports (slave modport of the ICB bundle)
//   s          : shared downstream port (master modport of the ICB bundle)
//   gnt        : registered one-hot grant, 00 when idle (bit N = master N)
//   busy       : high while a transaction is in CMD or RSP
module icb_rr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  icb_rr_arbiter_if.slave         m0,
  icb_rr_arbiter_if.slave         m1,
  icb_rr_arbiter_if.master        s,
  output logic [1:0]              gnt,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;

  // Granted master index and its muxed request signals.
  logic            sel;
  logic            sel_cmd_valid;
  logic            sel_rsp_ready;
  logic [AW-1:0]   sel_addr;
  logic            sel_read;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;   // m0 wins the first tie
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;

    sel           = gnt_q[1];
    sel_cmd_valid = sel ? m1.icb_cmd_valid : m0.icb_cmd_valid;
    sel_rsp_ready = sel ? m1.icb_rsp_ready : m0.icb_rsp_ready;
    sel_addr      = sel ? m1.icb_cmd_addr  : m0.icb_cmd_addr;
    sel_read      = sel ? m1.icb_cmd_read  : m0.icb_cmd_read;
    sel_wdata     = sel ? m1.icb_cmd_wdata : m0.icb_cmd_wdata;
    sel_wmask     = sel ? m1.icb_cmd_wmask : m0.icb_cmd_wmask;

    s.icb_cmd_valid = 1'b0;
    s.icb_cmd_addr  = '0;
    s.icb_cmd_read  = 1'b0;
    s.icb_cmd_wdata = '0;
    s.icb_cmd_wmask = '0;
    s.icb_rsp_ready = 1'b0;
    m0.icb_cmd_ready = 1'b0;
    m1.icb_cmd_ready = 1'b0;
    m0.icb_rsp_valid = 1'b0;
    m1.icb_rsp_valid = 1'b0;
    // Response data/error are broadcast; only rsp_valid is steered.
    m0.icb_rsp_rdata = s.icb_rsp_rdata;
    m0.icb_rsp_err   = s.icb_rsp_err;
    m1.icb_rsp_rdata = s.icb_rsp_rdata;
    m1.icb_rsp_err   = s.icb_rsp_err;

    unique case (state_q)
      IDLE: begin
        // Decision uses only the valids seen here; no valid->ready path.
        if (m0.icb_cmd_valid && m1.icb_cmd_valid) begin
          gnt_d   = last_q ? 2'b01 : 2'b10;
          state_d = CMD;
        end else if (m0.icb_cmd_valid) begin
          gnt_d   = 2'b01;
          state_d = CMD;
        end else if (m1.icb_cmd_valid) begin
          gnt_d   = 2'b10;
          state_d = CMD;
        end
      end

      CMD: begin
        s.icb_cmd_valid  = sel_cmd_valid;
        s.icb_cmd_addr   = sel_addr;
        s.icb_cmd_read   = sel_read;
        s.icb_cmd_wdata  = sel_wdata;
        s.icb_cmd_wmask  = sel_wmask;
        m0.icb_cmd_ready = !sel && s.icb_cmd_ready;
        m1.icb_cmd_ready =  sel && s.icb_cmd_ready;
        if (!sel_cmd_valid) begin
          // Requester withdrew before acceptance: abandon, keep last.
          state_d = IDLE;
          gnt_d   = '0;
        end else if (s.icb_cmd_ready) begin
          last_d  = sel;
          state_d = RSP;
        end
      end

      RSP: begin
        s.icb_rsp_ready  = sel_rsp_ready;
        m0.icb_rsp_valid = !sel && s.icb_rsp_valid;
        m1.icb_rsp_valid =  sel && s.icb_rsp_valid;
        if (s.icb_rsp_valid && sel_rsp_ready) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_icb_rr_arbiter.sv
module tb_icb_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icb_rr_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  icb_rr_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  icb_rr_arbiter_if #(.AW(AW), .DW(DW)) s_if ();
  logic [1:0] gnt;
  logic       busy;

  icb_rr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if),
    .gnt  (gnt),
    .busy (busy)
  );

  // Requester drive/observe arrays, index = master number.
  logic        mv[2], mrd[2], mrr[2];
  logic [31:0] maddr[2], mwd[2];
  logic [3:0]  mwm[2];
  logic        mcr[2], mrv[2];

  assign m0_if.icb_cmd_valid = mv[0];
  assign m0_if.icb_cmd_addr  = maddr[0];
  assign m0_if.icb_cmd_read  = mrd[0];
  assign m0_if.icb_cmd_wdata = mwd[0];
  assign m0_if.icb_cmd_wmask = mwm[0];
  assign m0_if.icb_rsp_ready = mrr[0];
  assign m1_if.icb_cmd_valid = mv[1];
  assign m1_if.icb_cmd_addr  = maddr[1];
  assign m1_if.icb_cmd_read  = mrd[1];
  assign m1_if.icb_cmd_wdata = mwd[1];
  assign m1_if.icb_cmd_wmask = mwm[1];
  assign m1_if.icb_rsp_ready = mrr[1];
  assign mcr[0] = m0_if.icb_cmd_ready;
  assign mcr[1] = m1_if.icb_cmd_ready;
  assign mrv[0] = m0_if.icb_rsp_valid;
  assign mrv[1] = m1_if.icb_rsp_valid;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  // Slave model: programmable command wait and response latency.
  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return a ^ 32'hB5A5_A5A5;
  endfunction

  logic        slv_rst_n = 1'b0;
  int          cmd_wait = 0;
  int          rsp_wait = 0;
  logic        stray = 1'b0;
  int          wcnt, rcnt;
  logic        pend;
  logic [31:0] paddr;

  assign s_if.icb_cmd_ready = s_if.icb_cmd_valid && (wcnt >= cmd_wait);
  assign s_if.icb_rsp_valid = (pend && (rcnt >= rsp_wait)) || stray;
  assign s_if.icb_rsp_rdata = slv_data(paddr);
  assign s_if.icb_rsp_err   = paddr[2];

  always @(posedge clk or negedge slv_rst_n) begin
    if (!slv_rst_n) begin
      wcnt <= 0; rcnt <= 0; pend <= 1'b0; paddr <= '0;
    end else begin
      if (s_if.icb_cmd_valid && s_if.icb_cmd_ready) begin
        wcnt <= 0; rcnt <= 0; pend <= 1'b1; paddr <= s_if.icb_cmd_addr;
      end else if (s_if.icb_cmd_valid) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (pend) begin
        if (s_if.icb_rsp_valid && s_if.icb_rsp_ready) pend <= 1'b0;
        else rcnt <= rcnt + 1;
      end
    end
  end

  // Scoreboard queues.
  typedef struct { int m; logic [31:0] addr; logic rd; logic [31:0] wdata; logic [3:0] wmask; } cmd_t;
  typedef struct { int m; logic [31:0] rdata; logic err; } rsp_t;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  task automatic expect_txn(input int m, input logic [31:0] a, input logic rd,
                            input logic [31:0] wd, input logic [3:0] wm);
    exp_cmd.push_back('{m, a, rd, wd, wm});
    exp_rsp.push_back('{m, slv_data(a), a[2]});
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_if.icb_cmd_valid && s_if.icb_cmd_ready) begin
        if (exp_cmd.size() == 0) fail_now("unexpected slave cmd");
        else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          chk("cmd grant", gnt, (e.m == 0) ? 2'b01 : 2'b10);
          chk("cmd addr", s_if.icb_cmd_addr, e.addr);
          chk("cmd read", s_if.icb_cmd_read, e.rd);
          chk("cmd wdata", s_if.icb_cmd_wdata, e.wdata);
          chk("cmd wmask", s_if.icb_cmd_wmask, e.wmask);
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (mrv[m] && mrr[m]) begin
          if (exp_rsp.size() == 0) fail_now("unexpected rsp");
          else begin
            rsp_t r;
            r = exp_rsp.pop_front();
            chk("rsp master", m, r.m);
            chk("rsp rdata", (m == 0) ? m0_if.icb_rsp_rdata : m1_if.icb_rsp_rdata, r.rdata);
            chk("rsp err", (m == 0) ? m0_if.icb_rsp_err : m1_if.icb_rsp_err, r.err);
          end
        end
      end
      chk("cmd_ready only to granted", {mcr[1], mcr[0]} & ~gnt, 2'b00);
      chk("rsp_valid only to granted", {mrv[1], mrv[0]} & ~gnt, 2'b00);
    end
  end

  // One full transaction from a requester; entered just after a posedge.
  task automatic do_txn(input int m, input logic [31:0] a, input logic rd,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input int rdy_delay, output int lat);
    bit ok;
    mv[m] = 1'b1; maddr[m] = a; mrd[m] = rd; mwd[m] = wd; mwm[m] = wm;
    mrr[m] = (rdy_delay == 0);
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (mcr[m]) begin lat = n; break; end
    end
    @(posedge clk); #1;
    mv[m] = 1'b0; maddr[m] = '0; mwd[m] = '0; mwm[m] = '0; mrd[m] = 1'b0;
    if (lat < 0) begin fail_now("cmd handshake"); mrr[m] = 1'b0; return; end
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (n > 0 || rdy_delay > 0) @(negedge clk);
      else @(negedge clk);
      if (mrv[m]) begin ok = 1; break; end
    end
    if (!ok) begin fail_now("rsp valid"); mrr[m] = 1'b0; return; end
    if (rdy_delay > 0) begin
      repeat (rdy_delay) @(posedge clk);
      #1 mrr[m] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    mrr[m] = 1'b0;
  endtask

  int lat_a, lat_b;

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; mrd[m] = 0; mrr[m] = 0; maddr[m] = '0; mwd[m] = '0; mwm[m] = '0;
    end
    // Reset with busy random inputs
    repeat (3) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        mv[m] = 1'b1; mrr[m] = 1'b1; mrd[m] = 1'($urandom);
        maddr[m] = $urandom; mwd[m] = $urandom; mwm[m] = 4'($urandom);
      end
      stray = 1'b1;
    end
    @(negedge clk);
    chk("reset gnt", gnt, 2'b00);
    chk("reset busy", busy, 1'b0);
    chk("reset cmd_ready", {mcr[1], mcr[0]}, 2'b00);
    chk("reset rsp_valid", {mrv[1], mrv[0]}, 2'b00);
    chk("reset s cmd_valid", s_if.icb_cmd_valid, 1'b0);
    chk("reset s payload", {s_if.icb_cmd_addr, s_if.icb_cmd_wdata}, 64'h0);
    chk("reset s wmask/read", {s_if.icb_cmd_wmask, s_if.icb_cmd_read}, 5'h0);
    chk("reset s rsp_ready", s_if.icb_rsp_ready, 1'b0);
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; mrr[m] = 0; mrd[m] = 0; maddr[m] = '0; mwd[m] = '0; mwm[m] = '0;
    end
    stray = 1'b0;
    slv_rst_n = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First read from m0, hand-computed response
    exp_cmd.push_back('{0, 32'h1000_0000, 1'b1, 32'h0, 4'h0});
    exp_rsp.push_back('{0, 32'hA5A5_A5A5, 1'b0});
    do_txn(0, 32'h1000_0000, 1'b1, 32'h0, 4'h0, 0, lat_a);
    chk("first cmd latency", lat_a, 1);

    // Stray response in IDLE
    stray = 1'b1;
    @(negedge clk);
    chk("stray s rsp_ready", s_if.icb_rsp_ready, 1'b0);
    chk("stray rsp_valid", {mrv[1], mrv[0]}, 2'b00);
    chk("stray busy", busy, 1'b0);
    @(posedge clk); #1 stray = 1'b0;

    // Backpressure on m1, m0 arrives during the window
    cmd_wait = 5; rsp_wait = 7;
    expect_txn(1, 32'h2000_0040, 1'b0, 32'h1111_2222, 4'hF);
    expect_txn(0, 32'h3000_0004, 1'b1, 32'h0, 4'h0);
    fork
      do_txn(1, 32'h2000_0040, 1'b0, 32'h1111_2222, 4'hF, 2, lat_a);
      begin
        repeat (3) @(posedge clk);
        #1 do_txn(0, 32'h3000_0004, 1'b1, 32'h0, 4'h0, 0, lat_b);
      end
      begin
        int k;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (gnt != 2'b00) break; end
        if (k == 50) fail_now("backpressure grant");
        for (k = 0; k < 100 && gnt != 2'b00; k++) begin
          chk("backpressure gnt", gnt, 2'b10);
          @(negedge clk);
        end
      end
    join
    chk("backpressure cmd wait", lat_a, 6);
    cmd_wait = 0; rsp_wait = 0;

    // m1 alone so last = 1
    expect_txn(1, 32'h2000_0100, 1'b0, 32'hDEAD_BEEF, 4'b0011);
    do_txn(1, 32'h2000_0100, 1'b0, 32'hDEAD_BEEF, 4'b0011, 0, lat_a);

    // Continuous tie: alternation starting with m0
    for (int i = 0; i < 4; i++) begin
      expect_txn(0, 32'h4000_0000 + 32'(i * 4), 1'b0, 32'hA000_0000 + 32'(i), 4'hF);
      expect_txn(1, 32'h5000_0000 + 32'(i * 4), 1'b0, 32'hB000_0000 + 32'(i), 4'h3);
    end
    fork
      for (int i = 0; i < 4; i++)
        do_txn(0, 32'h4000_0000 + 32'(i * 4), 1'b0, 32'hA000_0000 + 32'(i), 4'hF, 0, lat_a);
      for (int i = 0; i < 4; i++)
        do_txn(1, 32'h5000_0000 + 32'(i * 4), 1'b0, 32'hB000_0000 + 32'(i), 4'h3, 0, lat_b);
    join

    // m0 alone so last = 0, then m0 withdraws in CMD
    expect_txn(0, 32'h4000_0100, 1'b0, 32'h0BAD_F00D, 4'hC);
    do_txn(0, 32'h4000_0100, 1'b0, 32'h0BAD_F00D, 4'hC, 0, lat_a);
    cmd_wait = 3;
    mv[0] = 1'b1; maddr[0] = 32'h7000_0000; mrd[0] = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin @(negedge clk); if (gnt == 2'b01) break; end
      if (k == 20) fail_now("withdraw grant");
    end
    @(posedge clk); #1 mv[0] = 1'b0; maddr[0] = '0; mrd[0] = 1'b0;
    @(posedge clk); #1;
    chk("withdraw gnt", gnt, 2'b00);
    chk("withdraw busy", busy, 1'b0);
    cmd_wait = 0;

    // Tie after withdrawal: m1 wins since last stayed 0
    expect_txn(1, 32'h5000_0100, 1'b1, 32'h0, 4'h0);
    expect_txn(0, 32'h4000_0104, 1'b1, 32'h0, 4'h0);
    fork
      do_txn(0, 32'h4000_0104, 1'b1, 32'h0, 4'h0, 0, lat_a);
      do_txn(1, 32'h5000_0100, 1'b1, 32'h0, 4'h0, 0, lat_b);
    join

    // Reset while stalled in RSP
    rsp_wait = 2;
    exp_cmd.push_back('{0, 32'h6000_0000, 1'b1, 32'h0, 4'h0});
    mv[0] = 1'b1; maddr[0] = 32'h6000_0000; mrd[0] = 1'b1; mrr[0] = 1'b0;
    begin
      int k;
      for (k = 0; k < 20; k++) begin @(negedge clk); if (mcr[0]) break; end
      if (k == 20) fail_now("midreset cmd");
      @(posedge clk); #1 mv[0] = 1'b0; maddr[0] = '0; mrd[0] = 1'b0;
      for (k = 0; k < 20; k++) begin @(negedge clk); if (mrv[0]) break; end
      if (k == 20) fail_now("midreset rsp");
    end
    chk("midreset pre gnt", gnt, 2'b01);
    chk("midreset pre busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset gnt", gnt, 2'b00);
    chk("midreset busy", busy, 1'b0);
    chk("midreset rsp_valid", {mrv[1], mrv[0]}, 2'b00);
    chk("midreset s rsp_ready", s_if.icb_rsp_ready, 1'b0);
    @(posedge clk); #1 slv_rst_n = 1'b0;
    #1 slv_rst_n = 1'b1;
    rsp_wait = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie after reset: m0 wins
    expect_txn(0, 32'h4000_0200, 1'b0, 32'h1234_5678, 4'h1);
    expect_txn(1, 32'h5000_0204, 1'b0, 32'h8765_4321, 4'h8);
    fork
      do_txn(0, 32'h4000_0200, 1'b0, 32'h1234_5678, 4'h1, 0, lat_a);
      do_txn(1, 32'h5000_0204, 1'b0, 32'h8765_4321, 4'h8, 0, lat_b);
    join

    repeat (2) @(posedge clk);
    chk("cmd queue drained", exp_cmd.size(), 0);
    chk("rsp queue drained", exp_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
